// File: rtl/multi_code_system.sv
// multi_code_system: converts A/B to binary, Gray, excess-3 or BCD and compares them; one register stage
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid           sample A/B/mode on this edge
//   A, B [3:0]         unsigned operands
//   mode [1:0]         00 binary, 01 Gray, 10 excess-3, 11 BCD
//   convA, convB [3:0] converted operands
//   gt, lt, eq         raw unsigned compare of A and B
//   errA, errB         operand above 9 in a decimal code
//   out_valid          one-cycle strobe following each sampled in_valid
module multi_code_system (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [1:0] mode,
  output logic [3:0] convA,
  output logic [3:0] convB,
  output logic       gt,
  output logic       lt,
  output logic       eq,
  output logic       errA,
  output logic       errB,
  output logic       out_valid
);
  logic [3:0] ca, cb;
  logic       ea, eb;
  always_comb begin
    ca = mode == 2'b00 ? A : mode == 2'b01 ? A ^ (A >> 1) : mode == 2'b10 ? A + 4'd3 : (A > 4'd9 ? A - 4'd10 : A);
    cb = mode == 2'b00 ? B : mode == 2'b01 ? B ^ (B >> 1) : mode == 2'b10 ? B + 4'd3 : (B > 4'd9 ? B - 4'd10 : B);
    ea = mode[1] && A > 4'd9;
    eb = mode[1] && B > 4'd9;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      convA     <= '0;
      convB     <= '0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      errA      <= 1'b0;
      errB      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        convA <= ca;
        convB <= cb;
        gt    <= A > B;
        lt    <= A < B;
        eq    <= A == B;
        errA  <= ea;
        errB  <= eb;
      end
    end
  end
endmodule

// File: tb/tb_multi_code_system.sv
// tb_multi_code_system: directed vectors with hand-computed results for multi_code_system
module tb_multi_code_system;
  logic       clk = 1'b0;
  logic       rst_n, in_valid;
  logic [3:0] A, B, convA, convB;
  logic [1:0] mode;
  logic       gt, lt, eq, errA, errB, out_valid;
  int         checks = 0, errors = 0;
  logic [13:0] last_exp;
  multi_code_system dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B), .mode(mode),
    .convA(convA), .convB(convB), .gt(gt), .lt(lt), .eq(eq),
    .errA(errA), .errB(errB), .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  function automatic logic [13:0] obs();
    return {convA, convB, gt, lt, eq, errA, errB, out_valid};
  endfunction
  task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  // exp = {convA, convB, gt, lt, eq, errA, errB, out_valid}
  task automatic send(input string tag, input logic [1:0] m, input logic [3:0] a, input logic [3:0] b, input logic [13:0] exp);
    @(negedge clk);
    mode = m; A = a; B = b; in_valid = 1'b1;
    @(posedge clk);
    #1 chk(tag, obs(), exp);
    last_exp = exp;
  endtask
  task automatic idle(input string tag, input logic [1:0] m);
    @(negedge clk);
    in_valid = 1'b0; mode = m; A = 4'd1; B = 4'd14;
    @(posedge clk);
    #1 chk(tag, obs(), {last_exp[13:1], 1'b0});
  endtask
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; A = 4'd6; B = 4'd3; mode = 2'b00;
    #1 chk("reset_init", obs(), 14'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("idle_after_reset", obs(), 14'd0);
    send("bin_6_3",     2'b00, 4'd6,  4'd3,  {4'h6, 4'h3, 5'b10000, 1'b1});
    send("gray_5_7",    2'b01, 4'd5,  4'd7,  {4'h7, 4'h4, 5'b01000, 1'b1});
    send("xs3_2_6",     2'b10, 4'd2,  4'd6,  {4'h5, 4'h9, 5'b01000, 1'b1});
    send("bcd_9_4",     2'b11, 4'd9,  4'd4,  {4'h9, 4'h4, 5'b10000, 1'b1});
    send("bcd_12_12",   2'b11, 4'd12, 4'd12, {4'h2, 4'h2, 5'b00111, 1'b1});
    send("xs3_12_12",   2'b10, 4'd12, 4'd12, {4'hF, 4'hF, 5'b00111, 1'b1});
    send("bin_15_0",    2'b00, 4'd15, 4'd0,  {4'hF, 4'h0, 5'b10000, 1'b1});
    send("gray_15_8",   2'b01, 4'd15, 4'd8,  {4'h8, 4'hC, 5'b10000, 1'b1});
    send("xs3_13_9",    2'b10, 4'd13, 4'd9,  {4'h0, 4'hC, 5'b10010, 1'b1});
    send("bcd_10_0",    2'b11, 4'd10, 4'd0,  {4'h0, 4'h0, 5'b10010, 1'b1});
    send("xs3_9_10",    2'b10, 4'd9,  4'd10, {4'hC, 4'hD, 5'b01001, 1'b1});
    send("gray_0_0",    2'b01, 4'd0,  4'd0,  {4'h0, 4'h0, 5'b00100, 1'b1});
    idle("hold_1", 2'b11);
    idle("hold_mode_change", 2'b10);
    send("after_hold",  2'b10, 4'd1,  4'd14, {4'h4, 4'h1, 5'b01001, 1'b1});
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("reset_async", obs(), 14'd0);
    @(posedge clk);
    #1 chk("reset_held", obs(), 14'd0);
    @(negedge clk);
    rst_n = 1'b1; mode = 2'b00; A = 4'd3; B = 4'd8; in_valid = 1'b1;
    @(posedge clk);
    #1 chk("first_after_release", obs(), {4'h3, 4'h8, 5'b01000, 1'b1});
    @(negedge clk);
    mode = 2'b01; A = 4'd4; B = 4'd2;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 chk("inflight_discard", obs(), 14'd0);
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk);
    #1 chk("no_valid_after_discard", obs(), 14'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
